// File: rtl/inst_loader_pkg.sv
// Shared CPU definitions used by the instruction loader: memory depth,
// program terminator and the loader FSM state encoding.
package inst_loader_pkg;

    // Instruction-memory depth in 32-bit words.
    localparam int IMEM_DEPTH = 200;

    // Word that terminates a program image; it is itself written to memory.
    localparam logic [31:0] END_MARK_DEFAULT = 32'hffff_ffff;

    // Loader FSM states, kept as plain constants so older code can compare against them.
    localparam int LD_STATE_W = 2;
    typedef logic [LD_STATE_W-1:0] ld_state_t;

    localparam ld_state_t ST_IDLE = 2'd0;
    localparam ld_state_t ST_RECV = 2'd1;
    localparam ld_state_t ST_DONE = 2'd2;
    localparam ld_state_t ST_ERR  = 2'd3;

    // Position of the next byte inside the word being assembled.
    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        BYTE3 = 2'd3
    } byte_idx_e;

    // Big-endian join: the three bytes already held are the upper part of the word.
    function automatic logic [31:0] be_word(input logic [23:0] head, input logic [7:0] tail);
        return {head, tail};
    endfunction

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Four-byte big-endian assembler: collects bytes and flags the byte that
// completes a word, presenting the full word combinationally on that cycle.
module inst_loader_byte_assembler
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    byte_idx_e   idx_reg;
    byte_idx_e   idx_next;
    logic [23:0] head_reg;
    logic [23:0] head_next;

    // Only the first three bytes need storage; the fourth is joined on the fly
    // so the owner can register the finished word on the accepting edge.
    always_comb begin
        idx_next  = idx_reg;
        head_next = head_reg;
        if (clear) begin
            idx_next  = BYTE0;
            head_next = 24'd0;
        end else if (byte_en) begin
            idx_next  = byte_idx_e'(idx_reg + 2'd1);
            head_next = {head_reg[15:0], byte_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg  <= BYTE0;
            head_reg <= 24'd0;
        end else begin
            idx_reg  <= idx_next;
            head_reg <= head_next;
        end
    end

    assign word       = be_word(head_reg, byte_data);
    assign word_valid = byte_en && !clear && (idx_reg == BYTE3);

endmodule

// File: rtl/inst_loader.sv
// Serial program loader: assembles received bytes into 32-bit words and
// writes them to consecutive instruction-memory addresses until END_MARK.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int          DEPTH    = IMEM_DEPTH,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] END_MARK = END_MARK_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ld_state_t         state_reg;
    ld_state_t         state_next;
    logic              arm;
    logic              accept;
    logic              word_valid;
    logic [31:0]       word;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic [ADDR_W-1:0] word_count_reg;

    // Bytes are taken only while receiving; start in RECV is deliberately ignored.
    assign accept = (state_reg == ST_RECV) && rx_valid;

    inst_loader_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (arm),
        .byte_en    (accept),
        .byte_data  (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_next = state_reg;
        arm        = 1'b0;
        case (state_reg)
            ST_RECV: begin
                // Terminator is checked first so END_MARK in the last slot is a clean load.
                if (word_valid) begin
                    if (word == END_MARK) begin
                        state_next = ST_DONE;
                    end else if (word_count_reg == LAST_ADDR) begin
                        state_next = ST_ERR;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_next = ST_RECV;
                    arm        = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= 32'd0;
            word_count_reg <= '0;
        end else begin
            state_reg  <= state_next;
            mem_we_reg <= word_valid;
            if (arm) begin
                mem_addr_reg   <= '0;
                word_count_reg <= '0;
            end else if (word_valid) begin
                mem_addr_reg   <= word_count_reg;
                mem_wdata_reg  <= word;
                word_count_reg <= word_count_reg + ADDR_W'(1);
            end
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign word_count = word_count_reg;
    assign busy       = (state_reg == ST_RECV);
    assign done       = (state_reg == ST_DONE);
    assign error      = (state_reg == ST_ERR);

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: a default-depth and a DEPTH=4 instance
// share one stimulus stream and are compared against a word-level model.
`timescale 1ns/1ps
module tb_inst_loader;

    localparam int MD_IDLE = 0;
    localparam int MD_RECV = 1;
    localparam int MD_DONE = 2;
    localparam int MD_ERR  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;

    logic        b_we, b_busy, b_done, b_err;
    logic [7:0]  b_addr, b_wc;
    logic [31:0] b_wdata;
    logic        s_we, s_busy, s_done, s_err;
    logic [2:0]  s_addr, s_wc;
    logic [31:0] s_wdata;

    always #5 clk = ~clk;

    inst_loader #(.DEPTH(200), .ADDR_W(8), .END_MARK(32'hffffffff)) u_big (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .busy(b_busy), .done(b_done), .error(b_err), .word_count(b_wc)
    );

    inst_loader #(.DEPTH(4), .ADDR_W(3)) u_small (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .busy(s_busy), .done(s_done), .error(s_err), .word_count(s_wc)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cycle_n  = 0;

    logic [63:0] got0[$], got1[$], exp0[$], exp1[$];
    int          got_cyc0[$];

    always @(posedge clk) cycle_n <= cycle_n + 1;

    // Capture every write as {addr, data} midway through the cycle it is presented.
    always @(negedge clk) begin
        if (b_we) begin
            got0.push_back({32'(b_addr), b_wdata});
            got_cyc0.push_back(cycle_n);
        end
        if (s_we) got1.push_back({32'(s_addr), s_wdata});
    end

    // Word-level reference model, one slot per instance.
    int          m_mode[2];
    int          m_nbytes[2];
    int          m_cnt[2];
    logic [31:0] m_acc[2];
    int          m_depth[2] = '{200, 4};

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = MD_IDLE; m_nbytes[i] = 0; m_cnt[i] = 0; m_acc[i] = 32'd0;
        end
    endtask

    task automatic model_step(input logic s, input logic v, input logic [7:0] d);
        for (int i = 0; i < 2; i++) begin
            if (m_mode[i] != MD_RECV) begin
                if (s) begin
                    m_mode[i] = MD_RECV; m_nbytes[i] = 0; m_cnt[i] = 0; m_acc[i] = 32'd0;
                end
            end else if (v) begin
                m_acc[i] = m_acc[i] * 256 + 32'(d);
                m_nbytes[i] = m_nbytes[i] + 1;
                if (m_nbytes[i] == 4) begin
                    if (i == 0) exp0.push_back({32'(m_cnt[i]), m_acc[i]});
                    else        exp1.push_back({32'(m_cnt[i]), m_acc[i]});
                    m_cnt[i]    = m_cnt[i] + 1;
                    m_nbytes[i] = 0;
                    if (m_acc[i] == 32'hffffffff)     m_mode[i] = MD_DONE;
                    else if (m_cnt[i] == m_depth[i])  m_mode[i] = MD_ERR;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        start = s; rx_valid = v; rx_data = d;
        model_step(s, v, d);
        @(posedge clk);
        #1;
        start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        repeat (4) begin
            cyc(1'b0, 1'b1, t[31:24]);
            t = t << 8;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},    {b_we, s_we}, 2'b00);
        chk({tag, "_addr"},  {b_addr, s_addr}, 11'd0);
        chk({tag, "_wdata"}, {b_wdata, s_wdata}, 64'd0);
        chk({tag, "_flags"}, {b_busy, b_done, b_err, s_busy, s_done, s_err}, 6'd0);
        chk({tag, "_wc"},    {b_wc, s_wc}, 11'd0);
    endtask

    // Asynchronous pulse placed mid-cycle, away from both clock edges.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #2;
        check_reset_outputs(tag);
        #2;
        rst = 1'b0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_busy_b"}, b_busy, m_mode[0] == MD_RECV);
        chk({tag, "_done_b"}, b_done, m_mode[0] == MD_DONE);
        chk({tag, "_err_b"},  b_err,  m_mode[0] == MD_ERR);
        chk({tag, "_wc_b"},   32'(b_wc), 32'(m_cnt[0]));
        chk({tag, "_busy_s"}, s_busy, m_mode[1] == MD_RECV);
        chk({tag, "_done_s"}, s_done, m_mode[1] == MD_DONE);
        chk({tag, "_err_s"},  s_err,  m_mode[1] == MD_ERR);
        chk({tag, "_wc_s"},   32'(s_wc), 32'(m_cnt[1]));
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr_b"}, 64'(got0.size()), 64'(exp0.size()));
        for (int k = 0; k < got0.size() && k < exp0.size(); k++)
            chk($sformatf("%s_wr_b%0d", tag, k), got0[k], exp0[k]);
        chk({tag, "_nwr_s"}, 64'(got1.size()), 64'(exp1.size()));
        for (int k = 0; k < got1.size() && k < exp1.size(); k++)
            chk($sformatf("%s_wr_s%0d", tag, k), got1[k], exp1[k]);
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete(); got_cyc0.delete();
    endtask

    function automatic logic [63:0] entry(input logic [63:0] q[$], input int k);
        return (k < q.size()) ? q[k] : 64'hdead_dead_dead_dead;
    endfunction

    typedef struct {
        logic       s;
        logic       v;
        logic [7:0] d;
        logic       busy;
        logic       done;
        logic       err;
        int         wc;
    } vec_t;

    vec_t        vt[10];
    logic [31:0] gen_word;
    int          gen_k;

    initial begin
        // Nominal load of the default-depth instance, one row per cycle.
        vt[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0};
        vt[1] = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 0};
        vt[2] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 0};
        vt[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 0};
        vt[4] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vt[5] = '{1'b0, 1'b1, 8'hff, 1'b1, 1'b0, 1'b0, 1};
        vt[6] = '{1'b0, 1'b1, 8'hff, 1'b1, 1'b0, 1'b0, 1};
        vt[7] = '{1'b0, 1'b1, 8'hff, 1'b1, 1'b0, 1'b0, 1};
        vt[8] = '{1'b0, 1'b1, 8'hff, 1'b0, 1'b1, 1'b0, 2};
        vt[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2};

        model_reset();
        #3;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            cyc(vt[k].s, vt[k].v, vt[k].d);
            chk($sformatf("vec%0d_busy", k), b_busy, vt[k].busy);
            chk($sformatf("vec%0d_done", k), b_done, vt[k].done);
            chk($sformatf("vec%0d_err", k),  b_err,  vt[k].err);
            chk($sformatf("vec%0d_wc", k),   32'(b_wc), 32'(vt[k].wc));
        end
        chk("nominal_nwr", 64'(got0.size()), 64'd2);
        chk("nominal_w0", entry(got0, 0), {32'd0, 32'h20010000});
        chk("nominal_w1", entry(got0, 1), {32'd1, 32'hffffffff});
        check_writes("nominal");
        check_status("nominal");

        // Overflow on the 4-deep instance: fifth word must not be written.
        do_reset("rst_ovf");
        cyc(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) send_word(32'h10203040 + 32'(k));
        cyc(1'b0, 1'b0, 8'h00);
        chk("ovf_err_s", s_err, 1'b1);
        chk("ovf_nwr_s", 64'(got1.size()), 64'd4);
        chk("ovf_last_s", entry(got1, 3), {32'd3, 32'h10203043});
        check_writes("ovf");
        check_status("ovf");

        // Terminator landing in the last slot.
        do_reset("rst_last");
        cyc(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) send_word(32'hcafe0000 + 32'(k));
        send_word(32'hffffffff);
        cyc(1'b0, 1'b0, 8'h00);
        chk("last_flags_s", {s_done, s_err}, 2'b10);
        chk("last_w3_s", entry(got1, 3), {32'd3, 32'hffffffff});
        check_writes("last");
        check_status("last");

        // Reset in the middle of a word abandons the partial bytes.
        do_reset("rst_pre");
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'haa);
        cyc(1'b0, 1'b1, 8'hbb);
        do_reset("rst_mid");
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        send_word(32'h01020304);
        cyc(1'b0, 1'b0, 8'h00);
        chk("midrst_nwr", 64'(got0.size()), 64'd1);
        chk("midrst_w0", entry(got0, 0), {32'd0, 32'h01020304});
        check_writes("midrst");
        check_status("midrst");

        // Idle bytes ignored; restart after DONE discards the coincident byte.
        do_reset("rst_idle");
        for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 8'h55);
        cyc(1'b0, 1'b0, 8'h00);
        chk("idle_nwr", 64'(got0.size() + got1.size()), 64'd0);
        check_writes("idle");
        cyc(1'b1, 1'b0, 8'h00);
        send_word(32'hffffffff);
        cyc(1'b0, 1'b0, 8'h00);
        chk("restart_done1", b_done, 1'b1);
        check_writes("restart1");
        cyc(1'b1, 1'b1, 8'h12);
        cyc(1'b0, 1'b1, 8'h0a);
        cyc(1'b1, 1'b1, 8'h0b);
        cyc(1'b0, 1'b1, 8'h0c);
        cyc(1'b0, 1'b1, 8'h0d);
        cyc(1'b0, 1'b0, 8'h00);
        chk("restart_nwr", 64'(got0.size()), 64'd1);
        chk("restart_w0", entry(got0, 0), {32'd0, 32'h0a0b0c0d});
        check_writes("restart2");
        check_status("restart2");

        // Back-to-back bytes: one write every 4 cycles.
        do_reset("rst_b2b");
        cyc(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 32; k++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 254)));
        cyc(1'b0, 1'b0, 8'h00);
        chk("b2b_nwr", 64'(got0.size()), 64'd8);
        for (int k = 0; k < got0.size(); k++) begin
            chk($sformatf("b2b_addr%0d", k), 64'(got0[k][63:32]), 64'(k));
            if (k > 0)
                chk($sformatf("b2b_gap%0d", k), 64'(got_cyc0[k] - got_cyc0[k-1]), 64'd4);
        end
        check_writes("b2b");
        check_status("b2b");

        // Randomised traffic with sporadic starts and terminator words.
        do_reset("rst_rand");
        gen_word = $urandom();
        gen_k    = 0;
        for (int n = 0; n < 800; n++) begin
            logic       s, v;
            logic [7:0] d;
            s = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = 8'h00;
            if (v) begin
                d        = gen_word[31:24];
                gen_word = gen_word << 8;
                gen_k++;
                if (gen_k == 4) begin
                    gen_word = ($urandom_range(0, 4) == 0) ? 32'hffffffff : $urandom();
                    gen_k    = 0;
                end
            end
            cyc(s, v, d);
            check_status($sformatf("rand%0d", n));
            if (n % 16 == 15) begin
                cyc(1'b0, 1'b0, 8'h00);
                check_writes($sformatf("rand%0d", n));
            end
        end
        cyc(1'b0, 1'b0, 8'h00);
        check_writes("rand_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter DEPTH, default 200: number of instruction-memory words; legal addresses are 0..DEPTH-1.
REQ-002 Parameter ADDR_W, default 8: width of the write address and the word count; must satisfy 2**ADDR_W >= DEPTH.
REQ-003 Parameter END_MARK, default 32'hffffffff: terminator word that ends a program image.
REQ-004 clk  input  1  single clock for all state.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that arms a new load; honoured only in IDLE, DONE or ERR.
REQ-007 rx_data  input  8  byte from the serial receiver.
REQ-008 rx_valid  input  1  one-cycle strobe qualifying rx_data; there is no backpressure.
REQ-009 mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
REQ-010 mem_addr  output  ADDR_W  word write address.
REQ-011 mem_wdata  output  32  assembled instruction word.
REQ-012 busy  output  1  high in RECV.
REQ-013 done  output  1  high in DONE.
REQ-014 error  output  1  high in ERR, meaning overflow.
REQ-015 word_count  output  ADDR_W  words written in the current load, including the terminator.

Function
REQ-016 FSM states: IDLE, RECV, DONE, ERR.
- IDLE --start--> RECV
- DONE/ERR --start--> RECV
- No other transitions apart from those in REQ-022 and REQ-023.
REQ-017 Entering RECV clears: byte index, word_count, mem_addr, assembly register.
REQ-018 Byte acceptance: only rx_valid pulses in RECV are accepted; bytes arriving in any other state are discarded.
REQ-019 Byte order: big-endian. The first byte accepted goes to bits [31:24], the fourth to bits [7:0]; byte index wraps 3 -> 0.
REQ-020 Write timing: on the clock edge that accepts the 4th byte, register mem_wdata and mem_addr=word_count; mem_we is high for exactly the following cycle.
REQ-021 word_count increments on the same edge as REQ-020, so mem_addr then word_count present 0,1,2,... with no gaps.
REQ-022 Terminator: a word equal to END_MARK is written like any other word, then the FSM enters DONE on the same edge.
REQ-023 Overflow: if word_count reaches DEPTH without a terminator, the FSM enters ERR. No write is ever issued with mem_addr >= DEPTH.
REQ-024 Terminator at the last slot: an END_MARK word landing in address DEPTH-1 is a legal load and results in DONE, not ERR.
REQ-025 Simultaneous start and rx_valid in DONE/ERR: start wins, and that byte is discarded.
REQ-026 start while in RECV is ignored; a partial word is not flushed.
REQ-027 A partial word (1-3 bytes accepted) is never written.
REQ-028 Throughput: back-to-back rx_valid on every cycle is supported, giving one write per 4 cycles.

Reset
REQ-029 Asynchronous rst forces:
- state = IDLE
- mem_we = 0, mem_addr = 0, mem_wdata = 0
- word_count = 0, byte index = 0
- busy = 0, done = 0, error = 0
REQ-030 rst asserted mid-word or mid-load abandons the load; no mem_we pulse is issued during rst or on the first cycle after it is released.
REQ-031 Memory already written stays as it is; the loader does not clear memory.

Structure
REQ-032 The FSM state enum and the default END_MARK constant live in the shared CPU package, alongside the instruction-memory depth constant.
REQ-033 One sub-module is natural: byte_assembler, a 4-byte big-endian shift register with byte index and a word-valid pulse. The FSM and address counter stay in inst_loader.

Verification
REQ-034 Nominal load: start, then bytes 20 01 00 00 ff ff ff ff -> mem_we at addr 0 with 32'h20010000, then addr 1 with 32'hffffffff; done=1, word_count=2.
REQ-035 Overflow: with DEPTH=4, send 4 non-terminator words and then a 5th -> four writes to addrs 0..3, error=1, no write at addr 4.
REQ-036 Last-slot terminator: with DEPTH=4, send 3 words then ffffffff -> write at addr 3, done=1, error=0.
REQ-037 Reset mid-word: send 2 bytes, pulse rst, then start and a full 4-byte word -> a single write at addr 0 containing only the post-reset bytes.
REQ-038 Idle and restart: rx_valid bytes while IDLE produce no write; after DONE, a start coinciding with rx_valid discards that byte, and the next load starts again at addr 0.
REQ-039 Back-to-back input: 32 consecutive cycles with rx_valid high -> exactly 8 writes spaced 4 cycles apart at addrs 0..7.
